// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU definitions: divider FSM state encodings and the
//             ALU op codes that route DIVU/REMU to the sequential divider.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Divider FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // ALU op codes seen by the control unit
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_DIVU = 4'd8;
    localparam logic [3:0] ALU_REMU = 4'd9;

    // True for ops that must be launched on the sequential divider
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sub_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_sub_step
//  Purpose  : One restoring-division step. Trial subtraction S - {0,D} built
//             from ripple adder slices (B inverted, carry-in 1); selects the
//             restored or updated partial remainder and the quotient bit.
//  Revision : 1.0 - initial release
// ============================================================================
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   s_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_carry;
    logic             w_borrow;

    assign w_b        = ~{1'b0, d_i};
    assign w_carry[0] = 1'b1;

    // Full-adder slices forming S + ~D + 1
    for (genvar i = 0; i <= WIDTH; i++) begin : g_slice
        assign w_diff[i]      = s_i[i] ^ w_b[i] ^ w_carry[i];
        assign w_carry[i+1]   = (s_i[i] & w_b[i]) | (w_carry[i] & (s_i[i] ^ w_b[i]));
    end

    // No carry out of the top slice means S < D
    assign w_borrow = ~w_carry[WIDTH+1];
    assign r_next_o = w_borrow ? s_i : w_diff;
    assign q_bit_o  = ~w_borrow;

endmodule
`default_nettype wire

// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_32
//  Purpose  : Multi-cycle unsigned restoring divider, one trial subtraction
//             per clock. Launched by start, reports completion on busy/done.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider_32
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_r_next;
    logic             w_q_bit;
    // The MSB of R only exists so the trial subtraction cannot overflow;
    // after every step it is zero and it never feeds the next shift.
    logic             w_unused_r_msb;

    assign w_s            = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign w_unused_r_msb = r_q[WIDTH];

    div_sub_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .s_i      (w_s),
        .d_i      (d_q),
        .r_next_o (w_r_next),
        .q_bit_o  (w_q_bit)
    );

    // Next-state logic: FSM sequencing, shift-subtract iteration, result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    r_d     = '0;
                    d_d     = divisor;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = (divisor == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                r_d   = w_r_next;
                q_d   = {q_q[WIDTH-2:0], w_q_bit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // A zero divisor is the only way to reach FINISH with D == 0
                if (d_q == '0) begin
                    quo_d = '1;
                    rem_d = q_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = q_q;
                    rem_d = r_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
